// File: rtl/lc3_mmio_responder.sv
// LC-3 memory/IO responder: routes MIO requests to RAM or to the keyboard/display
// device registers and returns a one-cycle mem_r completion pulse.
//
// state    | meaning
// IDLE     | waiting for mem_en; device accesses complete on the accept edge
// DEV_RESP | device register response cycle (mem_r high)
// RAM_WAIT | ram_en issued, counting down RAM_LAT cycles to capture ram_rdata
// RAM_RESP | RAM response cycle (mem_r high)
module lc3_mmio_responder #(
  parameter int WIDTH   = 16,
  parameter int RAM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_en,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_r,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic             kb_valid,
  input  logic [7:0]       kb_data,
  output logic             kb_ready,
  output logic             dsp_valid,
  output logic [7:0]       dsp_data,
  input  logic             dsp_ready,
  output logic             kb_irq
);

  localparam int PAGE_LSB = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEV_RESP = 2'd1,
    RAM_WAIT = 2'd2,
    RAM_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic             kb_full_q, kb_full_d;
  logic             kb_ie_q, kb_ie_d;
  logic [7:0]       kbdr_q, kbdr_d;
  logic             dsp_rdy_q, dsp_rdy_d;
  logic             dsp_ie_q, dsp_ie_d;
  logic [7:0]       ddr_q, ddr_d;
  logic             dsp_valid_q, dsp_valid_d;

  // The device page is the top 512 addresses (xFE00-xFFFF at WIDTH=16).
  logic                is_dev;
  logic [PAGE_LSB-1:0] dev_off;
  logic                sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic [WIDTH-1:0]    dev_rdata;

  assign is_dev   = &addr[WIDTH-1:PAGE_LSB];
  assign dev_off  = addr[PAGE_LSB-1:0];
  assign sel_kbsr = is_dev && (dev_off == 9'h000);
  assign sel_kbdr = is_dev && (dev_off == 9'h002);
  assign sel_dsr  = is_dev && (dev_off == 9'h004);
  assign sel_ddr  = is_dev && (dev_off == 9'h006);

  always_comb begin
    dev_rdata = '0;
    if (sel_kbsr) begin
      dev_rdata = {kb_full_q, kb_ie_q, {(WIDTH-2){1'b0}}};
    end else if (sel_kbdr) begin
      dev_rdata = {{(WIDTH-8){1'b0}}, kbdr_q};
    end else if (sel_dsr) begin
      dev_rdata = {dsp_rdy_q, dsp_ie_q, {(WIDTH-2){1'b0}}};
    end else if (sel_ddr) begin
      dev_rdata = {{(WIDTH-8){1'b0}}, ddr_q};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    kb_full_d   = kb_full_q;
    kb_ie_d     = kb_ie_q;
    kbdr_d      = kbdr_q;
    dsp_rdy_d   = dsp_rdy_q;
    dsp_ie_d    = dsp_ie_q;
    ddr_d       = ddr_q;
    dsp_valid_d = dsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (mem_en) begin
          ram_addr_d  = addr;
          ram_wdata_d = wdata;
          ram_we_d    = mem_we;
          if (is_dev) begin
            state_d = DEV_RESP;
            if (!mem_we) begin
              rdata_d = dev_rdata;
              if (sel_kbdr) kb_full_d = 1'b0;
            end else if (sel_kbsr) begin
              kb_ie_d = wdata[WIDTH-2];
            end else if (sel_dsr) begin
              dsp_ie_d = wdata[WIDTH-2];
            end else if (sel_ddr && dsp_rdy_q) begin
              ddr_d       = wdata[7:0];
              dsp_rdy_d   = 1'b0;
              dsp_valid_d = 1'b1;
            end
          end else begin
            state_d  = RAM_WAIT;
            ram_en_d = 1'b1;
            cnt_d    = 3'(RAM_LAT);
          end
        end
      end
      DEV_RESP: state_d = IDLE;
      RAM_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RAM_RESP;
          if (!ram_we_q) rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RAM_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Peripheral handshakes run every cycle. A keyboard transfer only happens
    // when the buffer is empty, so it never collides with a KBDR read clear.
    if (kb_valid && !kb_full_q) begin
      kbdr_d    = kb_data;
      kb_full_d = 1'b1;
    end
    if (dsp_valid_q && dsp_ready) begin
      dsp_valid_d = 1'b0;
      dsp_rdy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      kb_full_q   <= 1'b0;
      kb_ie_q     <= 1'b0;
      kbdr_q      <= '0;
      dsp_rdy_q   <= 1'b1;
      dsp_ie_q    <= 1'b0;
      ddr_q       <= '0;
      dsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      kb_full_q   <= kb_full_d;
      kb_ie_q     <= kb_ie_d;
      kbdr_q      <= kbdr_d;
      dsp_rdy_q   <= dsp_rdy_d;
      dsp_ie_q    <= dsp_ie_d;
      ddr_q       <= ddr_d;
      dsp_valid_q <= dsp_valid_d;
    end
  end

  assign mem_r     = (state_q == DEV_RESP) || (state_q == RAM_RESP);
  assign rdata     = rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign kb_ready  = ~kb_full_q;
  assign kb_irq    = kb_full_q & kb_ie_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = ddr_q;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// Directed bench for lc3_mmio_responder: expected read data is queued when a
// request is driven and popped when mem_r completes it.
module tb_lc3_mmio_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en, mem_we;
  logic [15:0] addr, wdata, rdata;
  logic        mem_r, ram_en, ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        kb_valid, kb_ready;
  logic [7:0]  kb_data;
  logic        dsp_valid, dsp_ready, kb_irq;
  logic [7:0]  dsp_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  lc3_mmio_responder #(.WIDTH(16), .RAM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mem_r(mem_r),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
    .kb_irq(kb_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic kb_push(input logic [7:0] d);
    kb_valid = 1'b1;
    kb_data  = d;
    tick();
    kb_valid = 1'b0;
  endtask

  // Issue one request, hold mem_en until mem_r, check latency, read data and
  // that mem_r lasts a single cycle. Returns mid-way through the IDLE cycle.
  task automatic req(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input int exp_lat, input string tag);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    mem_en = 1'b1;
    mem_we = we;
    addr   = a;
    wdata  = d;
    if (!we) exp_q.push_back(exp_rd);
    tick();
    kb_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      mid();
      if (mem_r === 1'b1) begin
        lat = i;
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
    if (!we) begin
      if (got) chk({tag, " rdata"}, rdata, exp_q.pop_front());
      else void'(exp_q.pop_front());
    end
    tick();
    mem_en = 1'b0;
    mid();
    chk({tag, " mem_r pulse"}, {15'd0, mem_r}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ram_en_exp;
    logic [5:0] mem_r_exp;

    reset = 1'b1; mem_en = 1'b0; mem_we = 1'b0; addr = '0; wdata = '0;
    ram_rdata = 16'hDEAD; kb_valid = 1'b0; kb_data = '0; dsp_ready = 1'b0;
    tick(); tick();
    mid();
    chk("rst mem_r", {15'd0, mem_r}, 16'd0);
    chk("rst rdata", rdata, 16'h0000);
    chk("rst ram_en", {15'd0, ram_en}, 16'd0);
    chk("rst ram_we", {15'd0, ram_we}, 16'd0);
    chk("rst ram_addr", ram_addr, 16'h0000);
    chk("rst ram_wdata", ram_wdata, 16'h0000);
    chk("rst kb_ready", {15'd0, kb_ready}, 16'd1);
    chk("rst kb_irq", {15'd0, kb_irq}, 16'd0);
    chk("rst dsp_valid", {15'd0, dsp_valid}, 16'd0);
    chk("rst dsp_data", {8'd0, dsp_data}, 16'h0000);
    tick();
    reset = 1'b0;
    tick();

    // RAM read x3000, data presented only in cycle 3
    ram_en_exp = 6'b000010;
    mem_r_exp  = 6'b010000;
    mem_en = 1'b1; mem_we = 1'b0; addr = 16'h3000;
    exp_q.push_back(16'h1234);
    for (int c = 0; c < 6; c++) begin
      ram_rdata = (c == 3) ? 16'h1234 : 16'hDEAD;
      if (c == 5) mem_en = 1'b0;
      mid();
      chk($sformatf("ramrd ram_en c%0d", c), {15'd0, ram_en}, {15'd0, ram_en_exp[c]});
      chk($sformatf("ramrd mem_r c%0d", c), {15'd0, mem_r}, {15'd0, mem_r_exp[c]});
      if (c == 1) begin
        chk("ramrd ram_addr", ram_addr, 16'h3000);
        chk("ramrd ram_we", {15'd0, ram_we}, 16'd0);
      end
      if (c == 4) chk("ramrd rdata", rdata, exp_q.pop_front());
      tick();
    end

    // RAM write: same timing, rdata untouched, latched request visible
    req(1'b1, 16'h0100, 16'hBEEF, 16'h0000, LAT + 2, "ramwr");
    chk("ramwr ram_addr", ram_addr, 16'h0100);
    chk("ramwr ram_wdata", ram_wdata, 16'hBEEF);
    chk("ramwr ram_we", {15'd0, ram_we}, 16'd1);
    chk("ramwr rdata kept", rdata, 16'h1234);

    // Address map boundaries, back to back
    ram_rdata = 16'hCAFE;
    req(1'b0, 16'hFDFF, 16'h0000, 16'hCAFE, LAT + 2, "rd FDFF");
    req(1'b0, 16'hFE01, 16'h0000, 16'h0000, 1, "rd FE01");
    req(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, "rd FFFF");

    // Keyboard status/data sequence
    tick();
    kb_push(8'h41);
    mid();
    chk("kb ready full", {15'd0, kb_ready}, 16'd0);
    req(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1, "kbsr full");
    req(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1, "kbdr");
    req(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, "kbsr empty");
    chk("kb ready empty", {15'd0, kb_ready}, 16'd1);

    // Keyboard interrupt enable and KBDR write ignored
    req(1'b1, 16'hFE00, 16'h4000, 16'h0000, 1, "kbsr wr");
    req(1'b1, 16'hFE02, 16'h00AA, 16'h0000, 1, "kbdr wr");
    tick();
    kb_push(8'h55);
    mid();
    chk("kb_irq set", {15'd0, kb_irq}, 16'd1);
    req(1'b0, 16'hFE00, 16'h0000, 16'hC000, 1, "kbsr ie");
    req(1'b0, 16'hFE02, 16'h0000, 16'h0055, 1, "kbdr irq");
    chk("kb_irq clr", {15'd0, kb_irq}, 16'd0);

    // KBDR read clear colliding with a new keyboard byte: clear wins
    tick();
    kb_push(8'h66);
    kb_valid = 1'b1; kb_data = 8'h77;
    req(1'b0, 16'hFE02, 16'h0000, 16'h0066, 1, "kbdr race");
    req(1'b0, 16'hFE00, 16'h0000, 16'h4000, 1, "kbsr race");
    req(1'b0, 16'hFE02, 16'h0000, 16'h0066, 1, "kbdr kept");

    // Display
    dsp_ready = 1'b0;
    req(1'b1, 16'hFE06, 16'h0058, 16'h0000, 1, "ddr wr");
    chk("dsp_valid set", {15'd0, dsp_valid}, 16'd1);
    chk("dsp_data 58", {8'd0, dsp_data}, 16'h0058);
    req(1'b0, 16'hFE04, 16'h0000, 16'h0000, 1, "dsr busy");
    req(1'b1, 16'hFE06, 16'h0059, 16'h0000, 1, "ddr drop");
    chk("dsp_data kept", {8'd0, dsp_data}, 16'h0058);
    req(1'b0, 16'hFE06, 16'h0000, 16'h0058, 1, "ddr rd");
    tick();
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    mid();
    chk("dsp_valid clr", {15'd0, dsp_valid}, 16'd0);
    req(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1, "dsr rdy");
    req(1'b1, 16'hFE04, 16'h4000, 16'h0000, 1, "dsr wr");
    req(1'b0, 16'hFE04, 16'h0000, 16'hC000, 1, "dsr ie");

    // Reset in cycle 2 of a RAM read aborts it
    tick();
    mem_en = 1'b1; mem_we = 1'b0; addr = 16'h2000;
    tick();
    tick();
    reset = 1'b1; mem_en = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mid();
      chk($sformatf("abort mem_r c%0d", c), {15'd0, mem_r}, 16'd0);
      tick();
    end
    chk("abort dsp reset", {8'd0, dsp_data}, 16'h0000);
    req(1'b0, 16'hFE10, 16'h0000, 16'h0000, 1, "rd FE10");
    req(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1, "dsr after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
